// File: rtl/router_pkg.sv
// router_pkg: shared sizing defaults and header field positions for the 1x3 router.
package router_pkg;
    localparam int WIDTH        = 8;
    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;
endpackage

// File: rtl/router_fifo_mem.sv
// router_fifo_mem: DEPTH x (WIDTH+1) register array, one sync write port, one async read port.
module router_fifo_mem #(
    parameter int DEPTH  = router_pkg::DEPTH,
    parameter int WIDTH  = router_pkg::WIDTH,
    parameter int ADDR_W = router_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH:0]    wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [WIDTH:0]    rd
);
    logic [WIDTH:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;

    assign rd = mem[ra];
endmodule

// File: rtl/router_fifo.sv
// router_fifo: per-destination output FIFO with header tagging and packet byte tracking.
module router_fifo #(
    parameter int DEPTH  = router_pkg::DEPTH,
    parameter int WIDTH  = router_pkg::WIDTH,
    parameter int ADDR_W = router_pkg::ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst,
    input  logic             we,
    input  logic             re,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [6:0]       pkt_cnt,
    output logic             pkt_done,
    output logic             full,
    output logic             empty
);
    import router_pkg::*;

    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic [WIDTH:0]  rd_word;
    logic            wr_ok, rd_ok;
    logic [6:0]      hdr_cnt;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign wr_ok   = we && !full && !soft_rst;
    assign rd_ok   = re && !empty;
    // remaining bytes after the header: payload length plus the parity byte
    assign hdr_cnt = 7'(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]) + 7'd1;

    router_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_mem (
        .clk (clk),
        .we  (wr_ok),
        .wa  (wr_ptr[ADDR_W-1:0]),
        .wd  ({lfd_state, d_in}),
        .ra  (rd_ptr[ADDR_W-1:0]),
        .rd  (rd_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || soft_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            pkt_cnt    <= '0;
            pkt_done   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            dout_valid <= rd_ok;
            pkt_done   <= 1'b0;
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= rd_word[WIDTH-1:0];
                if (rd_word[WIDTH]) begin
                    pkt_cnt <= hdr_cnt;
                end else if (pkt_cnt != 7'd0) begin
                    pkt_cnt  <= pkt_cnt - 7'd1;
                    pkt_done <= pkt_cnt == 7'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: directed scenario tests for router_fifo, inputs driven and outputs sampled on negedge.
module tb_router_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       soft_rst = 1'b0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] d_in = '0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [6:0] pkt_cnt;
    logic       pkt_done;
    logic       full;
    logic       empty;
    int         tests = 0;
    int         fails = 0;

    router_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .soft_rst   (soft_rst),
        .we         (we),
        .re         (re),
        .lfd_state  (lfd_state),
        .d_in       (d_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .pkt_cnt    (pkt_cnt),
        .pkt_done   (pkt_done),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [7:0] d, input logic lfd);
        we = 1'b1; d_in = d; lfd_state = lfd;
        @(negedge clk);
        we = 1'b0; lfd_state = 1'b0;
    endtask

    task automatic rd();
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset empty: got %b want 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset full: got %b want 0", full); end
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset dout: got %h want 00", dout); end
        tests++; if (pkt_cnt !== 7'd0) begin fails++; $display("FAIL reset pkt_cnt: got %0d want 0", pkt_cnt); end
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset dout_valid: got %b want 0", dout_valid); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL post-reset empty: got %b want 1", empty); end
    endtask

    task automatic test_packet();
        logic [7:0] bytes [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5F};
        logic [6:0] cnt   [5] = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
        logic       done  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) wr(bytes[i], i == 0);
        for (int i = 0; i < 5; i++) begin
            rd();
            tests++; if (dout !== bytes[i]) begin fails++; $display("FAIL pkt dout[%0d]: got %h want %h", i, dout, bytes[i]); end
            tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL pkt dout_valid[%0d]: got %b want 1", i, dout_valid); end
            tests++; if (pkt_cnt !== cnt[i]) begin fails++; $display("FAIL pkt pkt_cnt[%0d]: got %0d want %0d", i, pkt_cnt, cnt[i]); end
            tests++; if (pkt_done !== done[i]) begin fails++; $display("FAIL pkt pkt_done[%0d]: got %b want %b", i, pkt_done, done[i]); end
        end
        @(negedge clk);
        tests++; if (pkt_done !== 1'b0) begin fails++; $display("FAIL pkt pkt_done pulse width: got %b want 0", pkt_done); end
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL pkt idle dout_valid: got %b want 0", dout_valid); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL pkt drained empty: got %b want 1", empty); end
    endtask

    task automatic test_full();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            tests++; if (full !== 1'b0) begin fails++; $display("FAIL full early[%0d]: got %b want 0", i, full); end
            wr(8'(8'h10 + i), 1'b0);
        end
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL full after 16: got %b want 1", full); end
        tests++; if (empty !== 1'b0) begin fails++; $display("FAIL full empty: got %b want 0", empty); end
        wr(8'hFF, 1'b0);
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL full after 17th: got %b want 1", full); end
        for (int i = 0; i < 16; i++) begin
            rd();
            exp = 8'(8'h10 + i);
            tests++; if (dout !== exp) begin fails++; $display("FAIL full dout[%0d]: got %h want %h", i, dout, exp); end
            tests++; if (pkt_cnt !== 7'd0) begin fails++; $display("FAIL full pkt_cnt[%0d]: got %0d want 0", i, pkt_cnt); end
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL full drained empty: got %b want 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL full drained full: got %b want 0", full); end
        rd();
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL empty-read dout_valid: got %b want 0", dout_valid); end
        tests++; if (dout !== 8'h1F) begin fails++; $display("FAIL empty-read dout hold: got %h want 1f", dout); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) wr(8'(8'h40 + i), 1'b0);
        for (int k = 0; k < 10; k++) begin
            we = 1'b1; re = 1'b1; d_in = 8'(8'h50 + k);
            @(negedge clk);
            exp = k < 8 ? 8'(8'h40 + k) : 8'(8'h50 + k - 8);
            tests++; if (dout !== exp) begin fails++; $display("FAIL b2b dout[%0d]: got %h want %h", k, dout, exp); end
            tests++; if (empty !== 1'b0 || full !== 1'b0) begin fails++; $display("FAIL b2b flags[%0d]: got empty=%b full=%b want 0 0", k, empty, full); end
        end
        we = 1'b0; re = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd();
            exp = 8'(8'h52 + i);
            tests++; if (dout !== exp) begin fails++; $display("FAIL b2b drain[%0d]: got %h want %h", i, dout, exp); end
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b occupancy: got empty=%b want 1", empty); end
    endtask

    task automatic test_soft_rst();
        wr(8'h0C, 1'b1); wr(8'hC1, 1'b0); wr(8'hC2, 1'b0); wr(8'hC3, 1'b0); wr(8'h3E, 1'b0);
        rd(); rd(); rd();
        tests++; if (pkt_cnt !== 7'd2) begin fails++; $display("FAIL soft pre pkt_cnt: got %0d want 2", pkt_cnt); end
        tests++; if (dout !== 8'hC2) begin fails++; $display("FAIL soft pre dout: got %h want c2", dout); end
        soft_rst = 1'b1; re = 1'b1; we = 1'b1; d_in = 8'h77;
        @(negedge clk);
        soft_rst = 1'b0; re = 1'b0; we = 1'b0;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL soft empty: got %b want 1", empty); end
        tests++; if (pkt_cnt !== 7'd0) begin fails++; $display("FAIL soft pkt_cnt: got %0d want 0", pkt_cnt); end
        tests++; if (pkt_done !== 1'b0) begin fails++; $display("FAIL soft pkt_done: got %b want 0", pkt_done); end
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL soft dout: got %h want 00", dout); end
        rd();
        tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL soft empty-read dout_valid: got %b want 0", dout_valid); end
        tests++; if (pkt_done !== 1'b0) begin fails++; $display("FAIL soft late pkt_done: got %b want 0", pkt_done); end
    endtask

    task automatic test_async_rst();
        wr(8'h08, 1'b1); wr(8'hB1, 1'b0); wr(8'hB2, 1'b0);
        re = 1'b1;
        @(negedge clk);
        tests++; if (pkt_cnt !== 7'd3 || dout !== 8'h08) begin fails++; $display("FAIL arst pre: got cnt=%0d dout=%h want 3 08", pkt_cnt, dout); end
        #2 rst = 1'b0;
        #1;
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL arst dout: got %h want 00", dout); end
        tests++; if (pkt_cnt !== 7'd0) begin fails++; $display("FAIL arst pkt_cnt: got %0d want 0", pkt_cnt); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL arst flags: got empty=%b full=%b want 1 0", empty, full); end
        tests++; if (dout_valid !== 1'b0 || pkt_done !== 1'b0) begin fails++; $display("FAIL arst valid/done: got %b %b want 0 0", dout_valid, pkt_done); end
        re = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wr(8'h00, 1'b1);
        rd();
        tests++; if (pkt_cnt !== 7'd1) begin fails++; $display("FAIL zero-len header pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_full();
        test_back_to_back();
        test_soft_rst();
        test_async_rst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
